// File: rtl/io_pattern_driver.sv
// GPIO pattern driver: ascending count 0x01..COUNT_MAX, then all-ones, then all-zeros, each held HOLD_CYCLES.
// Optional IO_PATTERN_READBACK_EN adds io_in/err pad readback checking.
module io_pattern_driver #(
  parameter int WIDTH       = 8,
  parameter int COUNT_MAX   = 10,
  parameter int HOLD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             abort,
`ifdef IO_PATTERN_READBACK_EN
  input  logic [WIDTH-1:0] io_in,
  output logic             err,
`endif
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oeb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] step_idx
);

  localparam int              HW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(COUNT_MAX);

  typedef enum logic [2:0] {IDLE, COUNT, ONES, ZEROS, DONE} state_t;

  state_t           state, state_nx;
  logic [HW-1:0]    hold_cnt, hold_nx;
  logic [WIDTH-1:0] out_nx, oeb_nx, step_nx;
  logic             busy_nx, done_nx;
  logic             step_end;

  // With HOLD_CYCLES=1 this is always true, so every active cycle advances.
  assign step_end = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      io_out   <= '0;
      io_oeb   <= '1;
      step_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      io_out   <= out_nx;
      io_oeb   <= oeb_nx;
      step_idx <= step_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    out_nx   = io_out;
    oeb_nx   = io_oeb;
    step_nx  = step_idx;
    busy_nx  = busy;
    done_nx  = done;

    if (abort) begin
      state_nx = IDLE;
      hold_nx  = '0;
      out_nx   = '0;
      oeb_nx   = '1;
      step_nx  = '0;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nx = COUNT;
            hold_nx  = '0;
            out_nx   = WIDTH'(1);
            oeb_nx   = '0;
            step_nx  = WIDTH'(1);
            busy_nx  = 1'b1;
            done_nx  = 1'b0;
          end
        end
        COUNT: begin
          if (step_end) begin
            hold_nx = '0;
            if (io_out == LAST_COUNT) begin
              state_nx = ONES;
              out_nx   = '1;
              step_nx  = '0;
            end else begin
              out_nx  = io_out + 1'b1;
              step_nx = io_out + 1'b1;
            end
          end else begin
            hold_nx = hold_cnt + 1'b1;
          end
        end
        ONES: begin
          if (step_end) begin
            state_nx = ZEROS;
            hold_nx  = '0;
            out_nx   = '0;
          end else begin
            hold_nx = hold_cnt + 1'b1;
          end
        end
        ZEROS: begin
          // Pads keep driving 0x00 after completion; only abort releases them.
          if (step_end) begin
            state_nx = DONE;
            hold_nx  = '0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end else begin
            hold_nx = hold_cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef IO_PATTERN_READBACK_EN
  logic err_nx;
  logic in_step;
  logic start_accept;

  assign in_step      = (state == COUNT) || (state == ONES) || (state == ZEROS);
  assign start_accept = start && ((state == IDLE) || (state == DONE));

  // Pads are sampled only on the final hold cycle so slow pad settling is tolerated.
  always_comb begin
    err_nx = err;
    if (abort || start_accept) begin
      err_nx = 1'b0;
    end else if (in_step && step_end && (io_in != io_out)) begin
      err_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      err <= 1'b0;
    end else begin
      err <= err_nx;
    end
  end
`endif

endmodule

// File: tb/tb_io_pattern_driver.sv
// Bench for io_pattern_driver: two instances (default and HOLD_CYCLES=1/COUNT_MAX=3) against a time-based model.
// Readback checks are included when IO_PATTERN_READBACK_EN is defined.
module tb_io_pattern_driver;

  localparam int HOLD_A = 16;
  localparam int CM_A   = 10;
  localparam int HOLD_B = 1;
  localparam int CM_B   = 3;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] oeb;
    logic [7:0] step;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       corrupt = 1'b0;
  logic [7:0] out_a, oeb_a, step_a, out_b, oeb_b, step_b;
  logic       busy_a, done_a, busy_b, done_b;
`ifdef IO_PATTERN_READBACK_EN
  logic [7:0] io_in_a, io_in_b;
  logic       err_a, err_b;
  assign io_in_a = corrupt ? 8'h00 : out_a;
  assign io_in_b = out_b;
`endif

  int checks = 0;
  int failures = 0;

  int mode [2];
  int tcnt [2];
  logic errm [2];

  always #5 clk = ~clk;

  io_pattern_driver #(.WIDTH(8), .COUNT_MAX(CM_A), .HOLD_CYCLES(HOLD_A)) dut_a (
    .clk(clk), .nRst(nRst), .start(start), .abort(abort),
`ifdef IO_PATTERN_READBACK_EN
    .io_in(io_in_a), .err(err_a),
`endif
    .io_out(out_a), .io_oeb(oeb_a), .busy(busy_a), .done(done_a), .step_idx(step_a)
  );

  io_pattern_driver #(.WIDTH(8), .COUNT_MAX(CM_B), .HOLD_CYCLES(HOLD_B)) dut_b (
    .clk(clk), .nRst(nRst), .start(start), .abort(abort),
`ifdef IO_PATTERN_READBACK_EN
    .io_in(io_in_b), .err(err_b),
`endif
    .io_out(out_b), .io_oeb(oeb_b), .busy(busy_b), .done(done_b), .step_idx(step_b)
  );

  function automatic int hold_of(int i);
    return (i == 0) ? HOLD_A : HOLD_B;
  endfunction

  function automatic int cm_of(int i);
    return (i == 0) ? CM_A : CM_B;
  endfunction

  // Outputs follow directly from elapsed time since the start edge.
  function automatic exp_t model_exp(int m, int t, int hold, int cm);
    exp_t e;
    int s;
    e = '{out: 8'h00, oeb: 8'hFF, step: 8'h00, busy: 1'b0, done: 1'b0};
    if (m == M_RUN) begin
      s = t / hold;
      e.oeb  = 8'h00;
      e.busy = 1'b1;
      if (s < cm) begin
        e.out  = 8'(s + 1);
        e.step = 8'(s + 1);
      end else if (s == cm) begin
        e.out = 8'hFF;
      end
    end else if (m == M_DONE) begin
      e.oeb  = 8'h00;
      e.done = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge nRst) begin
    exp_t e;
    logic mis;
    for (int i = 0; i < 2; i++) begin
      if (!nRst) begin
        mode[i] = M_IDLE;
        tcnt[i] = 0;
        errm[i] = 1'b0;
      end else begin
        e   = model_exp(mode[i], tcnt[i], hold_of(i), cm_of(i));
        mis = (i == 0) && corrupt && (mode[i] == M_RUN) &&
              (tcnt[i] % hold_of(i) == hold_of(i) - 1) && (e.out != 8'h00);
        if (abort) begin
          mode[i] = M_IDLE;
          tcnt[i] = 0;
          errm[i] = 1'b0;
        end else if (mode[i] != M_RUN && start) begin
          mode[i] = M_RUN;
          tcnt[i] = 0;
          errm[i] = 1'b0;
        end else if (mode[i] == M_RUN) begin
          if (mis) errm[i] = 1'b1;
          tcnt[i] = tcnt[i] + 1;
          if (tcnt[i] == (cm_of(i) + 2) * hold_of(i)) mode[i] = M_DONE;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model, away from the clock edge.
  always @(posedge clk) begin
    exp_t ea, eb;
    #2;
    ea = model_exp(mode[0], tcnt[0], HOLD_A, CM_A);
    eb = model_exp(mode[1], tcnt[1], HOLD_B, CM_B);
    check_output("a.io_out", out_a, ea.out);
    check_output("a.io_oeb", oeb_a, ea.oeb);
    check_output("a.step_idx", step_a, ea.step);
    check_output("a.busy", {7'd0, busy_a}, {7'd0, ea.busy});
    check_output("a.done", {7'd0, done_a}, {7'd0, ea.done});
    check_output("b.io_out", out_b, eb.out);
    check_output("b.io_oeb", oeb_b, eb.oeb);
    check_output("b.step_idx", step_b, eb.step);
    check_output("b.busy", {7'd0, busy_b}, {7'd0, eb.busy});
    check_output("b.done", {7'd0, done_b}, {7'd0, eb.done});
`ifdef IO_PATTERN_READBACK_EN
    check_output("a.err", {7'd0, err_a}, {7'd0, errm[0]});
    check_output("b.err", {7'd0, err_b}, {7'd0, errm[1]});
`endif
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_stimulus();
    // Directed: full default pattern with literal timing points.
    pulse_start();
    for (int t = 0; t <= 192; t++) begin
      case (t)
        0: begin
          check_output("lit.a.first", out_a, 8'h01);
          check_output("lit.a.oeb", oeb_a, 8'h00);
          check_output("lit.b.t0", out_b, 8'h01);
        end
        1: check_output("lit.b.t1", out_b, 8'h02);
        2: check_output("lit.b.t2", out_b, 8'h03);
        3: check_output("lit.b.t3", out_b, 8'hFF);
        4: check_output("lit.b.t4", out_b, 8'h00);
        5: check_output("lit.b.done", {7'd0, done_b}, 8'h01);
        15: check_output("lit.a.t15", out_a, 8'h01);
        16: check_output("lit.a.t16", out_a, 8'h02);
        159: check_output("lit.a.t159", out_a, 8'h0A);
        160: check_output("lit.a.ones", out_a, 8'hFF);
        176: check_output("lit.a.zeros", out_a, 8'h00);
        191: check_output("lit.a.busy191", {7'd0, busy_a, done_a}, 8'h02);
        192: begin
          check_output("lit.a.done192", {7'd0, busy_a, done_a}, 8'h01);
          check_output("lit.a.oeb_done", oeb_a, 8'h00);
        end
        default: ;
      endcase
      @(negedge clk);
    end

    // Start held high for the whole pattern must not restart it.
    start = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= 192; t++) begin
      if (t == 185) start = 1'b0;
      if (t == 100) check_output("lit.a.held100", out_a, 8'h07);
      if (t == 191) check_output("lit.a.held191", out_a, 8'h00);
      if (t == 192) check_output("lit.a.held_done", {7'd0, done_a}, 8'h01);
      @(negedge clk);
    end

    // Abort while showing 0x05, then restart.
    pulse_start();
    repeat (70) @(negedge clk);
    check_output("lit.a.pre_abort", out_a, 8'h05);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("lit.a.abort_out", out_a, 8'h00);
    check_output("lit.a.abort_oeb", oeb_a, 8'hFF);
    check_output("lit.a.abort_flags", {6'd0, busy_a, done_a}, 8'h00);
    pulse_start();
    check_output("lit.a.restart", out_a, 8'h01);

    // Asynchronous reset during ONES.
    repeat (165) @(negedge clk);
    check_output("lit.a.in_ones", out_a, 8'hFF);
    nRst = 1'b0;
    #1;
    check_output("lit.a.rst_out", out_a, 8'h00);
    check_output("lit.a.rst_oeb", oeb_a, 8'hFF);
    check_output("lit.a.rst_busy", {7'd0, busy_a}, 8'h00);
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    pulse_start();
    repeat (192) @(negedge clk);
    check_output("lit.a.rst_done", {7'd0, done_a}, 8'h01);

`ifdef IO_PATTERN_READBACK_EN
    // Corrupt the pads while 0x07 is shown (t = 96..111).
    pulse_start();
    for (int t = 0; t <= 192; t++) begin
      corrupt = (t >= 96 && t <= 111);
      if (t == 111) check_output("lit.a.err_before", {7'd0, err_a}, 8'h00);
      if (t == 112) check_output("lit.a.err_set", {7'd0, err_a}, 8'h01);
      if (t == 192) check_output("lit.a.err_sticky", {7'd0, err_a}, 8'h01);
      @(negedge clk);
    end
    corrupt = 1'b0;
    pulse_start();
    check_output("lit.a.err_clear", {7'd0, err_a}, 8'h00);
`endif

    // Randomized start/abort/reset traffic checked by the model every cycle.
    for (int n = 0; n < 4000; n++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 99) == 0);
`ifdef IO_PATTERN_READBACK_EN
      corrupt = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 799) == 0) nRst = 1'b0;
      else nRst = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    corrupt = 1'b0;
    nRst = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_output("lit.reset_oeb", oeb_a, 8'hFF);
    check_output("lit.reset_out", out_a, 8'h00);
    check_output("lit.reset_flags", {6'd0, busy_a, done_a}, 8'h00);
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
